// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared constants, state encoding and lane helpers for the
// FFT stage sequencer.
//   DATA_W   : bits per real or imag sample
//   N_POINTS : FFT points (lanes per frame bus)
//   STAGES   : radix-2 stages, log2(N_POINTS)
//   TIMEOUT  : max cycles spent in WAIT before the frame is aborted
package fft_seq_pkg;

    localparam int DATA_W   = 10;
    localparam int N_POINTS = 32;
    localparam int STAGES   = 5;
    localparam int TIMEOUT  = 64;
    localparam int BUS_W    = N_POINTS * DATA_W;
    localparam int CNT_W    = $clog2(TIMEOUT);
    localparam int IDX_W    = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_END,
        S_OUT
    } state_t;

    // Lane k of a packed frame bus lives in bits [k*DATA_W +: DATA_W].
    function automatic logic [DATA_W-1:0] lane_get(input logic [BUS_W-1:0] bus, input int k);
        return bus[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [4:0] bitrev5(input logic [4:0] k);
        return {k[0], k[1], k[2], k[3], k[4]};
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if: frame input/output handshake bundle.
//   in_valid/in_ready, in_real/in_imag     : frame into the sequencer
//   out_valid/out_ready, out_real/out_imag : finished frame out
// Modports: master = frame source/sink side, slave = sequencer side.
interface fft_stage_sequencer_if;
    import fft_seq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] in_real;
    logic [BUS_W-1:0] in_imag;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] out_real;
    logic [BUS_W-1:0] out_imag;

    modport master (
        output in_valid, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag
    );

    modport slave (
        input  in_valid, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag
    );

endinterface

// File: rtl/fft_bitrev_perm.sv
// fft_bitrev_perm: combinational 32-lane reorder, dst lane k = src lane
// bitrev5(k). Turns bit-reversed FFT output into natural order.
//   src : input frame bus
//   dst : permuted frame bus
module fft_bitrev_perm
    import fft_seq_pkg::*;
(
    input  logic [BUS_W-1:0] src,
    output logic [BUS_W-1:0] dst
);

    for (genvar k = 0; k < N_POINTS; k++) begin : g_lane
        assign dst[k*DATA_W +: DATA_W] = lane_get(src, int'(bitrev5(5'(k))));
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: loops one frame five times through a shared
// radix-2 butterfly stage unit, then presents the result.
//   clk, rst       : clock, synchronous active-high reset
//   frame          : in/out frame handshake (slave modport)
//   stg_start      : one-cycle pulse, butterfly FSM enable
//   stg_end        : one-cycle pulse, butterfly FSM end_f
//   stg_idx        : current stage 0..4, twiddle set select
//   stg_done       : stage result valid, sampled only in WAIT
//   stg_in_*       : working buffer to the stage unit
//   stg_out_*      : stage unit result
//   busy           : sequencer not idle
//   err            : one-cycle pulse when a stage times out
// Build option: FFT_SEQ_BITREV_EN reorders the output into natural order.
module fft_stage_sequencer
    import fft_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    fft_stage_sequencer_if.slave  frame,
    output logic                  stg_start,
    output logic                  stg_end,
    output logic [IDX_W-1:0]      stg_idx,
    input  logic                  stg_done,
    output logic [BUS_W-1:0]      stg_in_real,
    output logic [BUS_W-1:0]      stg_in_imag,
    input  logic [BUS_W-1:0]      stg_out_real,
    input  logic [BUS_W-1:0]      stg_out_imag,
    output logic                  busy,
    output logic                  err
);

    state_t           state;
    logic [IDX_W-1:0] stage;
    logic [CNT_W-1:0] wait_cnt;
    logic [BUS_W-1:0] work_real;
    logic [BUS_W-1:0] work_imag;

    // NOTE: every register here, strobes included, uses <= so all of them
    // update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            stage           <= '0;
            wait_cnt        <= '0;
            // NOTE: the wide work buffer is reset on purpose; stg_in_* and
            // out_* must read zero after reset, not leftover frame data.
            work_real       <= '0;
            work_imag       <= '0;
            frame.in_ready  <= 1'b1;
            frame.out_valid <= 1'b0;
            stg_start       <= 1'b0;
            stg_end         <= 1'b0;
            busy            <= 1'b0;
            err             <= 1'b0;
        end else begin
            stg_start <= 1'b0;
            stg_end   <= 1'b0;
            err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame.in_valid && frame.in_ready) begin
                        work_real      <= frame.in_real;
                        work_imag      <= frame.in_imag;
                        stage          <= '0;
                        state          <= S_START;
                        stg_start      <= 1'b1;
                        frame.in_ready <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                S_START: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (stg_done) begin
                        work_real <= stg_out_real;
                        work_imag <= stg_out_imag;
                        state     <= S_END;
                        stg_end   <= 1'b1;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Stage unit never answered: drop the frame.
                        err            <= 1'b1;
                        state          <= S_IDLE;
                        frame.in_ready <= 1'b1;
                        busy           <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_END: begin
                    if (stage == IDX_W'(STAGES - 1)) begin
                        state           <= S_OUT;
                        frame.out_valid <= 1'b1;
                    end else begin
                        stage     <= stage + IDX_W'(1);
                        state     <= S_START;
                        stg_start <= 1'b1;
                    end
                end
                S_OUT: begin
                    // in_ready rises only after this handshake, so a frame
                    // offered now is taken in the following IDLE cycle.
                    if (frame.out_ready) begin
                        frame.out_valid <= 1'b0;
                        frame.in_ready  <= 1'b1;
                        busy            <= 1'b0;
                        state           <= S_IDLE;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    frame.in_ready <= 1'b1;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

    assign stg_idx     = stage;
    assign stg_in_real = work_real;
    assign stg_in_imag = work_imag;

`ifdef FFT_SEQ_BITREV_EN
    fft_bitrev_perm u_perm_real (.src(work_real), .dst(frame.out_real));
    fft_bitrev_perm u_perm_imag (.src(work_imag), .dst(frame.out_imag));
`else
    assign frame.out_real = work_real;
    assign frame.out_imag = work_imag;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed self-checking bench for the FFT stage
// sequencer with a behavioural stage unit (per-stage done delay, optional
// stray done pulses in START/END, +inc per lane data model).
module tb_fft_stage_sequencer;
    import fft_seq_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             stg_start, stg_end, stg_done, busy, err;
    logic [IDX_W-1:0] stg_idx;
    logic [BUS_W-1:0] stg_in_real, stg_in_imag, stg_out_real, stg_out_imag;

    fft_stage_sequencer_if frame_if ();

    fft_stage_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .frame        (frame_if),
        .stg_start    (stg_start),
        .stg_end      (stg_end),
        .stg_idx      (stg_idx),
        .stg_done     (stg_done),
        .stg_in_real  (stg_in_real),
        .stg_in_imag  (stg_in_imag),
        .stg_out_real (stg_out_real),
        .stg_out_imag (stg_out_imag),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stage unit model controls.
    int         dly [STAGES];
    bit         glitch;
    logic [9:0] model_inc;
    int         wcnt;
    bit         armed;

    always_comb begin
        stg_out_real = '0;
        stg_out_imag = '0;
        for (int k = 0; k < N_POINTS; k++) begin
            stg_out_real[k*DATA_W +: DATA_W] = stg_in_real[k*DATA_W +: DATA_W] + model_inc;
            stg_out_imag[k*DATA_W +: DATA_W] = stg_in_imag[k*DATA_W +: DATA_W] + model_inc;
        end
    end

    // stg_done comes d WAIT cycles after the START cycle; optional stray
    // pulses are placed in START and END cycles.
    initial begin
        stg_done = 1'b0;
        armed    = 1'b0;
        wcnt     = 0;
    end

    always @(negedge clk) begin
        if (stg_start) begin
            wcnt     = 0;
            armed    = 1'b1;
            stg_done = glitch;
        end else if (armed) begin
            wcnt++;
            if (wcnt == dly[stg_idx]) begin
                stg_done = 1'b1;
                armed    = 1'b0;
            end else begin
                stg_done = 1'b0;
            end
        end else begin
            stg_done = glitch && stg_end;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] fill(input logic [DATA_W-1:0] v);
        return {N_POINTS{v}};
    endfunction

    function automatic logic [BUS_W-1:0] ramp();
        logic [BUS_W-1:0] r;
        for (int k = 0; k < N_POINTS; k++) r[k*DATA_W +: DATA_W] = DATA_W'(k);
        return r;
    endfunction

    function automatic bit in_set(input int c, input int s [5]);
        for (int i = 0; i < 5; i++) if (s[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    int st2 [5] = '{1, 4, 7, 13, 16};
    int en2 [5] = '{3, 6, 12, 15, 18};
    logic [BUS_W-1:0] v;

    initial begin
        rst                = 1'b1;
        frame_if.in_valid  = 1'b0;
        frame_if.out_ready = 1'b0;
        frame_if.in_real   = '0;
        frame_if.in_imag   = '0;
        model_inc          = 10'd1;
        glitch             = 1'b0;
        for (int i = 0; i < STAGES; i++) dly[i] = 1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state held through idle cycles.
        check("rst_out_real", frame_if.out_real, '0);
        check("rst_stg_in_real", stg_in_real, '0);
        for (int i = 0; i < 10; i++) begin
            check("idle_in_ready", frame_if.in_ready, 1);
            check("idle_strobes", {stg_start, stg_end, err, busy, frame_if.out_valid}, 0);
            check("idle_stg_idx", stg_idx, 0);
            tick();
        end

        // Nominal frame, d=1 on every stage; accept in cycle 0.
        frame_if.in_real  = fill(10'h001);
        frame_if.in_imag  = fill(10'h002);
        frame_if.in_valid = 1'b1;
        check("nom_c0_in_ready", frame_if.in_ready, 1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            frame_if.in_valid = 1'b0;
            check($sformatf("nom_start_c%0d", c), stg_start, (c <= 13 && c % 3 == 1));
            check($sformatf("nom_end_c%0d", c), stg_end, (c <= 15 && c % 3 == 0));
            check($sformatf("nom_oval_c%0d", c), frame_if.out_valid, (c == 16));
            if (c <= 13 && c % 3 == 1) check($sformatf("nom_idx_c%0d", c), stg_idx, (c - 1) / 3);
        end
        check("nom_out_real", frame_if.out_real, fill(10'h006));
        check("nom_out_imag", frame_if.out_imag, fill(10'h007));

        // Backpressure: out_ready low 7 cycles with a new frame pending.
        frame_if.in_real  = fill(10'h010);
        frame_if.in_imag  = fill(10'h020);
        frame_if.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("bp_out_valid", frame_if.out_valid, 1);
            check("bp_in_ready", frame_if.in_ready, 0);
            check("bp_out_hold", frame_if.out_real, fill(10'h006));
            check("bp_no_start", stg_start, 0);
            tick();
        end
        frame_if.out_ready = 1'b1;
        check("bp_hs_out_valid", frame_if.out_valid, 1);
        check("bp_hs_in_ready", frame_if.in_ready, 0);
        tick();
        frame_if.out_ready = 1'b0;
        check("bp_idle_out_valid", frame_if.out_valid, 0);
        check("bp_idle_in_ready", frame_if.in_ready, 1);
        check("bp_idle_no_start", stg_start, 0);

        // Second frame: d=4 on stage 2, stray done pulses in START/END.
        dly[2] = 4;
        glitch = 1'b1;
        tick();
        frame_if.in_valid = 1'b0;
        check("var_c1_start", stg_start, 1);
        check("var_c1_in_ready", frame_if.in_ready, 0);
        check("var_c1_idx", stg_idx, 0);
        for (int c = 2; c <= 19; c++) begin
            tick();
            check($sformatf("var_start_c%0d", c), stg_start, in_set(c, st2));
            check($sformatf("var_end_c%0d", c), stg_end, in_set(c, en2));
            check($sformatf("var_oval_c%0d", c), frame_if.out_valid, (c == 19));
        end
        check("var_out_real", frame_if.out_real, fill(10'h015));
        check("var_out_imag", frame_if.out_imag, fill(10'h025));
        frame_if.out_ready = 1'b1;
        tick();
        frame_if.out_ready = 1'b0;
        check("var_done_out_valid", frame_if.out_valid, 0);
        dly[2] = 1;
        glitch = 1'b0;

        // Timeout on stage 3: WAIT entered at cycle 11, err at 11+64.
        dly[3] = 1000;
        frame_if.in_real  = fill(10'h001);
        frame_if.in_valid = 1'b1;
        for (int c = 1; c <= 75; c++) begin
            tick();
            frame_if.in_valid = 1'b0;
            check($sformatf("to_err_c%0d", c), err, (c == 75));
        end
        check("to_in_ready", frame_if.in_ready, 1);
        check("to_busy", busy, 0);
        check("to_out_valid", frame_if.out_valid, 0);
        tick();
        check("to_err_clear", err, 0);
        check("to_out_valid2", frame_if.out_valid, 0);
        dly[3] = 1;

        // Reset mid-frame while stalled in WAIT.
        dly[0] = 1000;
        frame_if.in_valid = 1'b1;
        tick();
        frame_if.in_valid = 1'b0;
        check("mr_busy", busy, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_in_ready", frame_if.in_ready, 1);
        check("mr_busy_clear", busy, 0);
        check("mr_err", err, 0);
        tick();
        check("mr_err2", err, 0);
        check("mr_out_valid", frame_if.out_valid, 0);
        dly[0] = 1;

        // Bit-reverse: lane k = k, identity stage model.
        model_inc         = 10'd0;
        frame_if.in_real  = ramp();
        frame_if.in_imag  = ramp();
        frame_if.in_valid = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            frame_if.in_valid = 1'b0;
        end
        check("br_out_valid", frame_if.out_valid, 1);
        v = frame_if.out_real;
`ifdef FFT_SEQ_BITREV_EN
        check("br_lane1", v[1*DATA_W +: DATA_W], 16);
        check("br_lane3", v[3*DATA_W +: DATA_W], 24);
        check("br_lane2", v[2*DATA_W +: DATA_W], 8);
`else
        check("br_lane1", v[1*DATA_W +: DATA_W], 1);
        check("br_lane3", v[3*DATA_W +: DATA_W], 3);
        check("br_lane2", v[2*DATA_W +: DATA_W], 2);
`endif
        v = frame_if.out_imag;
        check("br_imag_lane31", v[31*DATA_W +: DATA_W], 31);
        frame_if.out_ready = 1'b1;
        tick();
        frame_if.out_ready = 1'b0;
        check("br_done_out_valid", frame_if.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
